delay_line_ctrl: RTL and testbench



---
 rtl/synth_pkg.sv | 21 ++
 rtl/delay_line_ctrl_if.sv | 14 +
 rtl/delay_line_ctrl.sv | 168 ++++++++++++++++
 tb/tb_delay_line_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path: delay-line FSM states,
// default widths and the circular-address wrap helper.
package synth_pkg;

   localparam int SAMPLE_W   = 18;
   localparam int DLY_ADDR_W = 12;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_DRAIN
   } dl_state_e;

   // Reduce an address expression modulo 2^w; callers do plain 32-bit math.
   function automatic logic [31:0] addr_wrap(input logic [31:0] v, input int w);
      return v & ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/delay_line_ctrl_if.sv
// Port bundle between the delay-line sequencer and the shared delay RAM
// (registered read address, combinational read data).
interface delay_line_ctrl_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 18
);
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic              ram_wren;
   logic [DATA_W-1:0] ram_dout;

   modport master (output ram_addr, output ram_din, output ram_wren, input ram_dout);
   modport slave  (input ram_addr, input ram_din, input ram_wren, output ram_dout);
endinterface

// File: rtl/delay_line_ctrl.sv
// Circular multi-tap delay line sequencer: one write then NUM_TAPS reads per
// sample strobe; taps stream out two cycles behind their RAM read address.
module delay_line_ctrl
   import synth_pkg::*;
#(
   parameter int NUM_TAPS       = 4,
   parameter int DATA_W         = SAMPLE_W,
   parameter int ADDR_W         = DLY_ADDR_W,
   parameter int TAP_W          = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                       clk,
   input  logic                       sclr,
   input  logic                       sample_en,
   input  logic [DATA_W-1:0]          sample_in,
   input  logic [NUM_TAPS*ADDR_W-1:0] delays,
   output logic                       busy,
   output logic                       tap_valid,
   output logic [TAP_W-1:0]           tap_idx,
   output logic [DATA_W-1:0]          tap_out,
   output logic                       frame_done,
   output logic                       overrun,
   delay_line_ctrl_if.master          ram
);

   dl_state_e                         state_q, state_d;
   logic [ADDR_W-1:0]                 wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]                 base_q, base_d;
   logic [NUM_TAPS-1:0][ADDR_W-1:0]   dly_q, dly_d;
   logic [TAP_W-1:0]                  cnt_q, cnt_d, cnt_nxt;
   logic                              busy_q, busy_d;
   logic                              wren_q, wren_d;
   logic [ADDR_W-1:0]                 addr_q, addr_d;
   logic [DATA_W-1:0]                 din_q, din_d;
   logic                              rd_vld_d;
   logic [TAP_W-1:0]                  rd_idx_d;
   // [0]: RAM address is a tap read this cycle; [1]: its data is on ram_dout
   logic [1:0]                        vld_pipe_q;
   logic [1:0][TAP_W-1:0]             idx_pipe_q;
   logic                              tap_valid_q, frame_done_q, overrun_q;
   logic [TAP_W-1:0]                  tap_idx_q;
   logic [DATA_W-1:0]                 tap_out_q;

   assign cnt_nxt = cnt_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      base_d   = base_q;
      dly_d    = dly_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      wren_d   = 1'b0;
      addr_d   = addr_q;
      din_d    = din_q;
      rd_vld_d = 1'b0;
      rd_idx_d = idx_pipe_q[0];
      unique case (state_q)
         ST_CLEAR: begin
            busy_d = 1'b1;
            din_d  = '0;
            if (!wren_q) begin
               wren_d = 1'b1;
               addr_d = '0;
            end else if (addr_q == {ADDR_W{1'b1}}) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               wren_d = 1'b1;
               addr_d = addr_q + 1'b1;
            end
         end
         ST_IDLE: begin
            busy_d = 1'b0;
            if (sample_en) begin
               state_d = ST_WRITE;
               busy_d  = 1'b1;
               base_d  = wr_ptr_q;
               dly_d   = delays;
               wren_d  = 1'b1;
               addr_d  = wr_ptr_q;
               din_d   = sample_in;
            end
         end
         ST_WRITE: begin
            wr_ptr_d = ADDR_W'(addr_wrap(32'(base_q) + 32'd1, ADDR_W));
            addr_d   = ADDR_W'(addr_wrap(32'(base_q) - 32'(dly_q[0]), ADDR_W));
            rd_vld_d = 1'b1;
            rd_idx_d = '0;
            cnt_d    = '0;
            state_d  = ST_READ;
         end
         ST_READ: begin
            if (cnt_q == TAP_W'(NUM_TAPS - 1)) begin
               cnt_d   = '0;
               state_d = ST_DRAIN;
            end else begin
               cnt_d    = cnt_nxt;
               addr_d   = ADDR_W'(addr_wrap(32'(base_q) - 32'(dly_q[cnt_nxt]), ADDR_W));
               rd_vld_d = 1'b1;
               rd_idx_d = cnt_nxt;
            end
         end
         ST_DRAIN: begin
            // two cycles let the last read pass through RAM and output register
            if (cnt_q == TAP_W'(1)) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_nxt;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         wr_ptr_q     <= '0;
         base_q       <= '0;
         dly_q        <= '0;
         cnt_q        <= '0;
         busy_q       <= CLEAR_ON_RESET;
         wren_q       <= 1'b0;
         addr_q       <= '0;
         din_q        <= '0;
         vld_pipe_q   <= '0;
         idx_pipe_q   <= '0;
         tap_valid_q  <= 1'b0;
         tap_idx_q    <= '0;
         tap_out_q    <= '0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         base_q        <= base_d;
         dly_q         <= dly_d;
         cnt_q         <= cnt_d;
         busy_q        <= busy_d;
         wren_q        <= wren_d;
         addr_q        <= addr_d;
         din_q         <= din_d;
         vld_pipe_q    <= {vld_pipe_q[0], rd_vld_d};
         idx_pipe_q    <= {idx_pipe_q[0], rd_idx_d};
         tap_valid_q   <= vld_pipe_q[1];
         if (vld_pipe_q[1]) begin
            tap_idx_q <= idx_pipe_q[1];
            tap_out_q <= ram.ram_dout;
         end
         frame_done_q  <= vld_pipe_q[1] && (idx_pipe_q[1] == TAP_W'(NUM_TAPS - 1));
         overrun_q     <= sample_en && busy_q;
      end
   end

   assign busy         = busy_q;
   assign tap_valid    = tap_valid_q;
   assign tap_idx      = tap_idx_q;
   assign tap_out      = tap_out_q;
   assign frame_done   = frame_done_q;
   assign overrun      = overrun_q;
   assign ram.ram_addr = addr_q;
   assign ram.ram_din  = din_q;
   assign ram.ram_wren = wren_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: behavioural RAM beside the DUT, sample-history
// reference model, randomized frames plus directed boundary scenarios.
module tb_delay_line_ctrl;
   import synth_pkg::*;

   localparam int N   = 4;
   localparam int DW  = 18;
   localparam int AW  = 12;
   localparam int TW  = 2;
   localparam int DLW = N * AW;
   localparam int DEPTH = 1 << AW;

   typedef logic [N-1:0][DW-1:0] tap_vec_t;
   typedef logic [N-1:0][AW-1:0] addr_vec_t;

   logic           clk = 1'b0;
   logic           sclr = 1'b1;
   logic           sample_en = 1'b0;
   logic [DW-1:0]  sample_in = '0;
   logic [DLW-1:0] delays = '0;
   logic           busy, tap_valid, frame_done, overrun;
   logic [TW-1:0]  tap_idx;
   logic [DW-1:0]  tap_out;

   int tests = 0;
   int fails = 0;

   delay_line_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

   delay_line_ctrl #(
      .NUM_TAPS(N), .DATA_W(DW), .ADDR_W(AW), .TAP_W(TW), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk(clk), .sclr(sclr), .sample_en(sample_en), .sample_in(sample_in),
      .delays(delays), .busy(busy), .tap_valid(tap_valid), .tap_idx(tap_idx),
      .tap_out(tap_out), .frame_done(frame_done), .overrun(overrun), .ram(ram_if)
   );

   always #5 clk = ~clk;

   // Delay RAM: registered read address, combinational data out
   logic [DW-1:0] mem [0:DEPTH-1];
   logic [AW-1:0] rd_addr_q;
   always @(posedge clk) begin
      if (ram_if.ram_wren) mem[ram_if.ram_addr] <= ram_if.ram_din;
      rd_addr_q <= ram_if.ram_addr;
   end
   assign ram_if.ram_dout = mem[rd_addr_q];

   // Reference model: every accepted sample since the last clear, oldest first
   logic [DW-1:0] hist[$];

   function automatic logic [DW-1:0] model_tap(input int n, input int d);
      return (d <= n) ? hist[n-d] : '0;
   endfunction

   task automatic run_frame(input logic [DW-1:0] s, input logic [DLW-1:0] d,
                            output tap_vec_t obs, output tap_vec_t exp,
                            output logic [AW-1:0] waddr, output logic [AW-1:0] exp_waddr,
                            output addr_vec_t raddr, output addr_vec_t exp_raddr,
                            output int terr);
      int n, dk;
      terr = 0; obs = '0; raddr = '0; exp = '0; exp_raddr = '0;
      @(negedge clk);
      if (busy !== 1'b0) terr++;
      sample_en = 1'b1; sample_in = s; delays = d;
      @(negedge clk);
      sample_en = 1'b0; sample_in = DW'($urandom()); delays = DLW'({$urandom(), $urandom()});
      waddr = ram_if.ram_addr;
      if (ram_if.ram_wren !== 1'b1 || ram_if.ram_din !== s || busy !== 1'b1) terr++;
      hist.push_back(s);
      n = hist.size() - 1;
      exp_waddr = AW'(n % DEPTH);
      for (int k = 0; k < N; k++) begin
         dk = int'(d[k*AW +: AW]);
         exp[k] = model_tap(n, dk);
         exp_raddr[k] = AW'((n - dk + DEPTH) % DEPTH);
      end
      for (int c = 2; c <= 3 + N; c++) begin
         @(negedge clk);
         if (busy !== 1'b1 || ram_if.ram_wren !== 1'b0 || overrun !== 1'b0) terr++;
         if (c <= 1 + N) raddr[c-2] = ram_if.ram_addr;
         if (c >= 4) begin
            if (tap_valid !== 1'b1 || tap_idx !== TW'(c - 4)) terr++;
            obs[c-4] = tap_out;
         end else if (tap_valid !== 1'b0) terr++;
         if (frame_done !== (c == 3 + N)) terr++;
      end
   endtask

   task automatic test_reset;
      int errs = 0;
      bit ov_ok = 1'b0;
      logic [1+1+TW+DW+1+1+AW+DW+1-1:0] act, req;
      sample_en = 1'b0;
      @(negedge clk); sclr = 1'b1;
      @(negedge clk);
      act = {busy, tap_valid, tap_idx, tap_out, frame_done, overrun,
             ram_if.ram_addr, ram_if.ram_din, ram_if.ram_wren};
      req = '0; req[$bits(req)-1] = 1'b1;
      tests++;
      if (act !== req) begin
         fails++; $display("FAIL reset_values: got %h want %h", act, req);
      end
      sclr = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         if (ram_if.ram_wren !== 1'b1 || ram_if.ram_din !== '0 ||
             ram_if.ram_addr !== AW'(i) || busy !== 1'b1) errs++;
         if (i == 101) ov_ok = (overrun === 1'b1);
         sample_en = (i == 100);
         sample_in = 18'h3ffff;
      end
      tests++;
      if (errs != 0) begin
         fails++; $display("FAIL clear_sweep: %0d bad cycles, want 0", errs);
      end
      tests++;
      if (!ov_ok) begin
         fails++; $display("FAIL overrun_in_clear: overrun not 1 after strobe during clear");
      end
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || ram_if.ram_wren !== 1'b0) begin
         fails++; $display("FAIL clear_end: busy=%b wren=%b want 0 0", busy, ram_if.ram_wren);
      end
      hist.delete();
   endtask

   task automatic test_first_frame;
      tap_vec_t obs, exp; addr_vec_t ra, era; logic [AW-1:0] wa, ewa; int terr;
      run_frame(18'h00123, {12'd3, 12'd2, 12'd1, 12'd0}, obs, exp, wa, ewa, ra, era, terr);
      tests++;
      if (obs !== {18'h0, 18'h0, 18'h0, 18'h00123} || terr != 0 || wa !== '0) begin
         fails++; $display("FAIL first_frame: taps=%h terr=%0d waddr=%0d want taps=%h terr=0 waddr=0",
                           obs, terr, wa, {18'h0, 18'h0, 18'h0, 18'h00123});
      end
      tests++;
      if (ra !== era) begin
         fails++; $display("FAIL first_frame_raddr: got %h want %h", ra, era);
      end
      @(negedge clk);
      tests++;
      if (tap_valid !== 1'b0 || tap_out !== obs[N-1]) begin
         fails++; $display("FAIL tap_hold: valid=%b out=%h want 0 %h", tap_valid, tap_out, obs[N-1]);
      end
   endtask

   task automatic test_five_frames;
      tap_vec_t obs, exp; addr_vec_t ra, era; logic [AW-1:0] wa, ewa; int terr;
      for (int f = 1; f <= 5; f++) begin
         run_frame(DW'(f), {12'd4, 12'd3, 12'd2, 12'd1}, obs, exp, wa, ewa, ra, era, terr);
         if (f == 1) begin
            tests++;
            if (wa !== AW'(1)) begin
               fails++; $display("FAIL next_base: waddr=%0d want 1", wa);
            end
         end
         tests++;
         if (obs !== exp || ra !== era || terr != 0) begin
            fails++; $display("FAIL five_frames f%0d: taps=%h want %h terr=%0d", f, obs, exp, terr);
         end
      end
      tests++;
      if (obs !== {18'd1, 18'd2, 18'd3, 18'd4}) begin
         fails++; $display("FAIL five_frames_last: taps=%h want %h", obs, {18'd1, 18'd2, 18'd3, 18'd4});
      end
   endtask

   task automatic test_random;
      tap_vec_t obs, exp; addr_vec_t ra, era; logic [AW-1:0] wa, ewa; int terr;
      logic [DLW-1:0] d;
      for (int f = 0; f < 30; f++) begin
         for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 5))
               0:       d[k*AW +: AW] = '0;
               1:       d[k*AW +: AW] = {AW{1'b1}};
               default: d[k*AW +: AW] = AW'($urandom_range(0, 12));
            endcase
         end
         run_frame(DW'($urandom()), d, obs, exp, wa, ewa, ra, era, terr);
         tests++;
         if (obs !== exp || ra !== era || wa !== ewa || terr != 0) begin
            fails++;
            $display("FAIL random f%0d: taps=%h want %h raddr=%h want %h waddr=%0d want %0d terr=%0d",
                     f, obs, exp, ra, era, wa, ewa, terr);
         end
      end
   endtask

   task automatic test_overrun;
      tap_vec_t obs = '0, exp = '0;
      logic [DW-1:0] a = 18'h2aaaa;
      logic [DLW-1:0] d = {12'd0, 12'd1, 12'd0, 12'd2};
      int n, wr_cnt = 0, ov_bad = 0;
      @(negedge clk);
      sample_en = 1'b1; sample_in = a; delays = d;
      hist.push_back(a);
      n = hist.size() - 1;
      for (int k = 0; k < N; k++) exp[k] = model_tap(n, int'(d[k*AW +: AW]));
      for (int c = 1; c <= 3 + N; c++) begin
         @(negedge clk);
         if (ram_if.ram_wren === 1'b1) wr_cnt++;
         if (overrun !== (c == 3)) ov_bad++;
         if (c >= 4) obs[c-4] = tap_out;
         sample_en = (c == 2);
         sample_in = 18'h15555;
      end
      tests++;
      if (ov_bad != 0) begin
         fails++; $display("FAIL overrun_pulse: %0d bad cycles, want 0", ov_bad);
      end
      tests++;
      if (wr_cnt != 1) begin
         fails++; $display("FAIL overrun_writes: %0d writes, want 1", wr_cnt);
      end
      tests++;
      if (obs !== exp) begin
         fails++; $display("FAIL overrun_taps: taps=%h want %h", obs, exp);
      end
   endtask

   task automatic test_sclr_midframe;
      tap_vec_t obs, exp; addr_vec_t ra, era; logic [AW-1:0] wa, ewa; int terr;
      int bad = 0, wait_cyc = 0;
      @(negedge clk);
      sample_en = 1'b1; sample_in = 18'h11111; delays = '0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         sample_en = 1'b0;
      end
      sclr = 1'b1;
      @(negedge clk);
      if (tap_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b1) bad++;
      sclr = 1'b0;
      @(negedge clk);
      if (ram_if.ram_wren !== 1'b1 || ram_if.ram_addr !== '0) bad++;
      while (busy !== 1'b0 && wait_cyc < 5000) begin
         if (tap_valid !== 1'b0 || frame_done !== 1'b0) bad++;
         @(negedge clk);
         wait_cyc++;
      end
      tests++;
      if (bad != 0 || wait_cyc >= 5000) begin
         fails++; $display("FAIL sclr_abort: %0d bad cycles, clear cycles=%0d", bad, wait_cyc);
      end
      hist.delete();
      run_frame(18'h0beef, {12'd3, 12'd2, 12'd1, 12'd0}, obs, exp, wa, ewa, ra, era, terr);
      tests++;
      if (wa !== '0 || obs !== {18'h0, 18'h0, 18'h0, 18'h0beef} || terr != 0) begin
         fails++; $display("FAIL sclr_wrptr: waddr=%0d taps=%h terr=%0d want 0 %h 0",
                           wa, obs, terr, {18'h0, 18'h0, 18'h0, 18'h0beef});
      end
   endtask

   task automatic test_wrap;
      tap_vec_t obs, exp; addr_vec_t ra, era; logic [AW-1:0] wa, ewa; int terr;
      int bad = 0, wait_cyc = 0;
      @(negedge clk); sclr = 1'b1;
      @(negedge clk); sclr = 1'b0;
      while (busy !== 1'b0 && wait_cyc < 5000) begin
         @(negedge clk);
         wait_cyc++;
      end
      tests++;
      if (wait_cyc >= 5000) begin
         fails++; $display("FAIL wrap_clear_timeout: busy still %b", busy);
      end
      hist.delete();
      for (int f = 1; f <= DEPTH + 1; f++) begin
         run_frame(DW'(f), {12'd2, 12'd1, 12'd0, 12'd4095}, obs, exp, wa, ewa, ra, era, terr);
         if (obs !== exp || ra !== era || wa !== ewa || terr != 0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL wrap_frames: %0d bad frames, want 0", bad);
      end
      tests++;
      if (wa !== '0 || ra[0] !== AW'(1) || obs[0] !== DW'(2)) begin
         fails++; $display("FAIL wrap_last: waddr=%0d raddr0=%0d tap0=%0d want 0 1 2", wa, ra[0], obs[0]);
      end
   endtask

   initial begin
      test_reset;
      test_first_frame;
      test_five_frames;
      test_random;
      test_overrun;
      test_sclr_midframe;
      test_wrap;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
